// File: rtl/eth_st_sink.sv
// eth_st_sink: Avalon-ST packet sink that validates framing on incoming
// 64-bit beats and writes well-formed packets into a downstream FIFO.
// Orphan beats are discarded. Packets cut short by a new SOP are left
// partially written. Over-length packets are truncated, with the EOP bit
// forced on the last word that fits.
//
// Ports
//   csi_clk, rsi_reset_n       clock, async active-low reset
//   asi_ready/valid/data       Avalon-ST sink handshake and 64-bit payload
//   asi_startofpacket          SOP marker for the beat
//   asi_endofpacket            EOP marker for the beat
//   fifo_data, fifo_write      {eop, sop, data} word and its write strobe
//   fifo_almost_full           FIFO has 2 or fewer free words
//   cnt_clear                  synchronous clear of the statistics counters
//   pkt_done, pkt_len          completion pulse and beat count of the last packet
//   pkt_count                  packets completed (wrapping)
//   err_orphan, err_no_eop,    saturating error counters
//   err_trunc
module eth_st_sink #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  output logic        asi_ready,
  input  logic        asi_valid,
  input  logic [63:0] asi_data,
  input  logic        asi_startofpacket,
  input  logic        asi_endofpacket,
  output logic [65:0] fifo_data,
  output logic        fifo_write,
  input  logic        fifo_almost_full,
  input  logic        cnt_clear,
  output logic        pkt_done,
  output logic [15:0] pkt_len,
  output logic [31:0] pkt_count,
  output logic [7:0]  err_orphan,
  output logic [7:0]  err_no_eop,
  output logic [7:0]  err_trunc
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

  state_t      state;
  state_t      next_state;
  logic [15:0] wcnt;
  logic [15:0] next_wcnt;
  logic [16:0] wcnt_inc;
  logic        beat_ok;
  logic        start_pkt;
  logic        do_write;
  logic        wr_eop;
  logic        inc_orphan;
  logic        inc_no_eop;
  logic        inc_trunc;

  assign beat_ok = asi_valid & asi_ready;

  // Beat decode. A beat that opens a new packet (from IDLE, from RECV when
  // EOP was missing, or from DROP when SOP arrives without EOP) is funnelled
  // through start_pkt, so all three cases share one set of rules.
  always_comb begin
    next_state = state;
    next_wcnt  = wcnt;
    do_write   = 1'b0;
    wr_eop     = 1'b0;
    inc_orphan = 1'b0;
    inc_no_eop = 1'b0;
    inc_trunc  = 1'b0;
    start_pkt  = 1'b0;
    wcnt_inc   = {1'b0, wcnt} + 17'd1;
    if (beat_ok) begin
      case (state)
        IDLE: begin
          if (asi_startofpacket) begin
            start_pkt = 1'b1;
          end else begin
            inc_orphan = 1'b1;
            next_state = asi_endofpacket ? IDLE : DROP;
          end
        end
        RECV: begin
          if (asi_startofpacket) begin
            inc_no_eop = 1'b1;
            start_pkt  = 1'b1;
          end else begin
            do_write  = 1'b1;
            next_wcnt = wcnt_inc[15:0];
            if (asi_endofpacket) begin
              wr_eop     = 1'b1;
              next_state = IDLE;
            end else if (wcnt_inc == MAX_W17) begin
              wr_eop     = 1'b1;
              inc_trunc  = 1'b1;
              next_state = DROP;
            end
          end
        end
        DROP: begin
          // SOP+EOP while dropping is swallowed; it only ends the drop.
          if (asi_startofpacket && !asi_endofpacket) begin
            start_pkt = 1'b1;
          end else if (asi_endofpacket) begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
      if (start_pkt) begin
        do_write   = 1'b1;
        next_wcnt  = 16'd1;
        wr_eop     = asi_endofpacket;
        next_state = asi_endofpacket ? IDLE : RECV;
      end
    end
  end

  // Ready follows the state being entered, so DROP keeps draining beats
  // even while the FIFO is nearly full. When cnt_clear coincides with an
  // increment, the clear is assigned last and takes effect.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state      <= IDLE;
      wcnt       <= 16'd0;
      asi_ready  <= 1'b0;
      fifo_write <= 1'b0;
      fifo_data  <= 66'd0;
      pkt_done   <= 1'b0;
      pkt_len    <= 16'd0;
      pkt_count  <= 32'd0;
      err_orphan <= 8'd0;
      err_no_eop <= 8'd0;
      err_trunc  <= 8'd0;
    end else begin
      state      <= next_state;
      wcnt       <= next_wcnt;
      asi_ready  <= (next_state == DROP) | ~fifo_almost_full;
      fifo_write <= do_write;
      pkt_done   <= do_write & wr_eop;
      if (do_write) begin
        fifo_data <= {wr_eop, asi_startofpacket, asi_data};
      end
      if (do_write && wr_eop) begin
        pkt_len   <= next_wcnt;
        pkt_count <= pkt_count + 32'd1;
      end
      if (inc_orphan && err_orphan != 8'hFF) begin
        err_orphan <= err_orphan + 8'd1;
      end
      if (inc_no_eop && err_no_eop != 8'hFF) begin
        err_no_eop <= err_no_eop + 8'd1;
      end
      if (inc_trunc && err_trunc != 8'hFF) begin
        err_trunc <= err_trunc + 8'd1;
      end
      if (cnt_clear) begin
        pkt_count  <= 32'd0;
        err_orphan <= 8'd0;
        err_no_eop <= 8'd0;
        err_trunc  <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_eth_st_sink.sv
// tb_eth_st_sink: randomized and directed stimulus for eth_st_sink,
// compared against a packet-level reference model. Expected FIFO words are
// queued as beats are accepted, and a negedge monitor pops and compares
// them whenever the DUT writes.
module tb_eth_st_sink;

  localparam int MAX_W = 4;

  logic        csi_clk           = 1'b0;
  logic        rsi_reset_n       = 1'b0;
  logic        asi_ready;
  logic        asi_valid         = 1'b0;
  logic [63:0] asi_data          = 64'd0;
  logic        asi_startofpacket = 1'b0;
  logic        asi_endofpacket   = 1'b0;
  logic [65:0] fifo_data;
  logic        fifo_write;
  logic        fifo_almost_full  = 1'b0;
  logic        cnt_clear         = 1'b0;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic [31:0] pkt_count;
  logic [7:0]  err_orphan;
  logic [7:0]  err_no_eop;
  logic [7:0]  err_trunc;

  int checks      = 0;
  int failures    = 0;
  int write_count = 0;
  bit rand_en     = 1'b0;

  // Reference model state, tracked per packet rather than per FSM state.
  bit          m_in_pkt    = 1'b0;
  bit          m_dropping  = 1'b0;
  int          m_beats     = 0;
  logic [65:0] exp_q[$];
  logic        exp_ready   = 1'b0;
  logic        exp_done    = 1'b0;
  logic [15:0] exp_len     = 16'd0;
  logic [31:0] exp_count   = 32'd0;
  logic [7:0]  exp_orphan  = 8'd0;
  logic [7:0]  exp_no_eop  = 8'd0;
  logic [7:0]  exp_trunc   = 8'd0;

  eth_st_sink #(.MAX_WORDS(MAX_W)) dut (
    .csi_clk           (csi_clk),
    .rsi_reset_n       (rsi_reset_n),
    .asi_ready         (asi_ready),
    .asi_valid         (asi_valid),
    .asi_data          (asi_data),
    .asi_startofpacket (asi_startofpacket),
    .asi_endofpacket   (asi_endofpacket),
    .fifo_data         (fifo_data),
    .fifo_write        (fifo_write),
    .fifo_almost_full  (fifo_almost_full),
    .cnt_clear         (cnt_clear),
    .pkt_done          (pkt_done),
    .pkt_len           (pkt_len),
    .pkt_count         (pkt_count),
    .err_orphan        (err_orphan),
    .err_no_eop        (err_no_eop),
    .err_trunc         (err_trunc)
  );

  always #5 csi_clk = ~csi_clk;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic void finish_pkt();
    exp_done  = 1'b1;
    exp_len   = m_beats[15:0];
    exp_count = exp_count + 32'd1;
  endfunction

  // One accepted beat, described by packet framing rules.
  function automatic void model_beat(input bit s, input bit e, input logic [63:0] d);
    if (s && !(m_dropping && e)) begin
      if (m_in_pkt) exp_no_eop = sat_inc(exp_no_eop);
      m_dropping = 1'b0;
      m_beats    = 1;
      exp_q.push_back({e, 1'b1, d});
      if (e) begin
        finish_pkt();
        m_in_pkt = 1'b0;
      end else begin
        m_in_pkt = 1'b1;
      end
    end else if (s) begin
      m_dropping = 1'b0;
    end else if (m_in_pkt) begin
      m_beats++;
      if (e) begin
        exp_q.push_back({1'b1, 1'b0, d});
        finish_pkt();
        m_in_pkt = 1'b0;
      end else if (m_beats == MAX_W) begin
        exp_q.push_back({1'b1, 1'b0, d});
        exp_trunc = sat_inc(exp_trunc);
        finish_pkt();
        m_in_pkt   = 1'b0;
        m_dropping = 1'b1;
      end else begin
        exp_q.push_back({1'b0, 1'b0, d});
      end
    end else if (m_dropping) begin
      if (e) m_dropping = 1'b0;
    end else begin
      exp_orphan = sat_inc(exp_orphan);
      if (!e) m_dropping = 1'b1;
    end
  endfunction

  // Model update at each active edge; the handshake is sampled before the
  // DUT's registers update.
  always @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      m_in_pkt   = 1'b0;
      m_dropping = 1'b0;
      m_beats    = 0;
      exp_q.delete();
      exp_ready  = 1'b0;
      exp_done   = 1'b0;
      exp_len    = 16'd0;
      exp_count  = 32'd0;
      exp_orphan = 8'd0;
      exp_no_eop = 8'd0;
      exp_trunc  = 8'd0;
    end else begin
      exp_done = 1'b0;
      if (asi_valid && asi_ready) model_beat(asi_startofpacket, asi_endofpacket, asi_data);
      if (cnt_clear) begin
        exp_count  = 32'd0;
        exp_orphan = 8'd0;
        exp_no_eop = 8'd0;
        exp_trunc  = 8'd0;
      end
      exp_ready = m_dropping || !fifo_almost_full;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge csi_clk) begin
    if (!rsi_reset_n) begin
      checkOutput("reset_outputs",
                  {asi_ready, fifo_write, pkt_done, fifo_data, pkt_len, pkt_count,
                   err_orphan, err_no_eop, err_trunc}, 160'd0);
    end else begin
      checkOutput("asi_ready", asi_ready, exp_ready);
      if (fifo_write) begin
        write_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write actual=%0h required=no_write", fifo_data);
        end else begin
          checkOutput("fifo_data", fifo_data, exp_q.pop_front());
        end
      end
      checkOutput("pkt_done", pkt_done, exp_done);
      checkOutput("pkt_len", pkt_len, exp_len);
      checkOutput("pkt_count", pkt_count, exp_count);
      checkOutput("err_orphan", err_orphan, exp_orphan);
      checkOutput("err_no_eop", err_no_eop, exp_no_eop);
      checkOutput("err_trunc", err_trunc, exp_trunc);
    end
  end

  // Background back-pressure and statistic clears for the random phase.
  always @(negedge csi_clk) begin
    if (rand_en) begin
      fifo_almost_full = ($urandom_range(0, 99) < 25);
      cnt_clear        = ($urandom_range(0, 99) < 3);
    end
  end

  // Presents one beat starting at a falling edge and holds it until accepted.
  task automatic applyStimulus(input bit s, input bit e, input logic [63:0] d);
    int waited = 0;
    asi_valid         = 1'b1;
    asi_startofpacket = s;
    asi_endofpacket   = e;
    asi_data          = d;
    while (!asi_ready) begin
      @(negedge csi_clk);
      waited++;
      if (waited > 500) begin
        checks++;
        failures++;
        $display("[TB] FAIL handshake_timeout actual=ready_low required=ready_high");
        break;
      end
    end
    @(negedge csi_clk);
    asi_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    asi_valid = 1'b0;
    repeat (n) @(negedge csi_clk);
  endtask

  task automatic clear_stats();
    cnt_clear = 1'b1;
    @(negedge csi_clk);
    cnt_clear = 1'b0;
  endtask

  initial begin
    int wc0;
    repeat (3) @(negedge csi_clk);
    rsi_reset_n = 1'b1;
    idle(2);

    // Four-beat packet.
    applyStimulus(1'b1, 1'b0, 64'h1);
    applyStimulus(1'b0, 1'b0, 64'h2);
    applyStimulus(1'b0, 1'b0, 64'h3);
    applyStimulus(1'b0, 1'b1, 64'h4);
    idle(3);
    checkOutput("t1_pkt_count", pkt_count, 32'd1);
    checkOutput("t1_pkt_len", pkt_len, 16'd4);

    // Orphan beat, then a single-beat packet.
    clear_stats();
    wc0 = write_count;
    applyStimulus(1'b0, 1'b1, 64'h55);
    applyStimulus(1'b1, 1'b1, 64'hAA);
    idle(3);
    checkOutput("t2_err_orphan", err_orphan, 8'd1);
    checkOutput("t2_writes", write_count - wc0, 1);
    checkOutput("t2_fifo_data", fifo_data, {2'b11, 64'hAA});
    checkOutput("t2_pkt_count", pkt_count, 32'd1);

    // Six-beat packet truncated at four words.
    clear_stats();
    wc0 = write_count;
    for (int i = 0; i < 6; i++) applyStimulus(i == 0, i == 5, 64'h100 + 64'(i));
    idle(3);
    checkOutput("t3_writes", write_count - wc0, 4);
    checkOutput("t3_err_trunc", err_trunc, 8'd1);
    checkOutput("t3_pkt_len", pkt_len, 16'd4);

    // Missing EOP: three-beat fragment, then a complete three-beat packet.
    clear_stats();
    wc0 = write_count;
    for (int i = 0; i < 3; i++) applyStimulus(i == 0, 1'b0, 64'h200 + 64'(i));
    for (int i = 0; i < 3; i++) applyStimulus(i == 0, i == 2, 64'h300 + 64'(i));
    idle(3);
    checkOutput("t4_err_no_eop", err_no_eop, 8'd1);
    checkOutput("t4_writes", write_count - wc0, 6);
    checkOutput("t4_pkt_count", pkt_count, 32'd1);
    checkOutput("t4_pkt_len", pkt_len, 16'd3);

    // Back-pressure in the middle of a packet with valid held.
    clear_stats();
    applyStimulus(1'b1, 1'b0, 64'h400);
    fifo_almost_full = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h401);
    checkOutput("t5_ready_low", asi_ready, 1'b0);
    fork
      applyStimulus(1'b0, 1'b1, 64'h402);
      begin
        repeat (5) @(negedge csi_clk);
        fifo_almost_full = 1'b0;
      end
    join
    idle(3);
    checkOutput("t5_pkt_len", pkt_len, 16'd3);

    // Reset during beat two of four, then a clean packet.
    applyStimulus(1'b1, 1'b0, 64'h500);
    applyStimulus(1'b0, 1'b0, 64'h501);
    #2 rsi_reset_n = 1'b0;
    repeat (3) @(negedge csi_clk);
    rsi_reset_n = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) applyStimulus(i == 0, i == 3, 64'h600 + 64'(i));
    idle(3);
    checkOutput("t6_pkt_count", pkt_count, 32'd1);
    checkOutput("t6_pkt_len", pkt_len, 16'd4);

    // Random framing with back-pressure and statistic clears.
    rand_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 35,
                    {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_en = 1'b0;
    fifo_almost_full = 1'b0;
    cnt_clear = 1'b0;
    idle(4);

    // Orphan counter saturation.
    clear_stats();
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 64'(i));
    idle(3);
    checkOutput("orphan_saturated", err_orphan, 8'hFF);

    checkOutput("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_st_sink.md
ETH_ST_SINK -- requirements
Module: eth_st_sink

Interface
REQ-001 Parameter MAX_WORDS, default 1024, maximum beats per packet written to the FIFO (2..65535).
REQ-002 csi_clk  input  1  single clock; all logic on rising edge.
REQ-003 rsi_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 asi_ready  output  1  Avalon-ST sink ready, registered, readyLatency 0.
REQ-005 asi_valid  input  1  beat valid.
REQ-006 asi_data  input  64  beat data.
REQ-007 asi_startofpacket  input  1  first beat of packet.
REQ-008 asi_endofpacket  input  1  last beat of packet.
REQ-009 fifo_data  output  66  {eop, sop, data[63:0]} written to FIFO.
REQ-010 fifo_write  output  1  FIFO write strobe, one word per cycle high.
REQ-011 fifo_almost_full  input  1  high when FIFO has 2 or fewer free words.
REQ-012 cnt_clear  input  1  synchronous clear of all statistics.
REQ-013 pkt_done  output  1  one-cycle pulse when a packet's last word is written.
REQ-014 pkt_len  output  16  beat count of the last packet written, truncated length if truncated.
REQ-015 pkt_count  output  32  packets written, wraps at 2^32.
REQ-016 err_orphan, err_no_eop, err_trunc  output  8 each  saturating error counters (stop at 255).

Function
REQ-017 Beat accepted iff asi_valid and asi_ready both high in the same cycle; no other beat has effect.
REQ-018 asi_ready next value: 1 in DROP; otherwise NOT fifo_almost_full.
REQ-019 States IDLE, RECV, DROP; word counter wcnt 16 bits.
REQ-020 IDLE, accepted beat with sop: write it, wcnt=1; eop also high -> single-beat packet, stay IDLE; else go RECV.
REQ-021 IDLE, accepted beat without sop: discard, err_orphan+1; with eop stay IDLE, without eop go DROP.
REQ-022 RECV, accepted beat without sop: write it, wcnt+1; with eop -> packet complete, go IDLE.
REQ-023 RECV, accepted beat with sop (missing EOP): err_no_eop+1, prior partial packet left as written, new beat treated as IDLE+sop per REQ-020.
REQ-024 RECV, beat making wcnt==MAX_WORDS without eop: write it with fifo eop bit forced 1, err_trunc+1, pkt_done pulses, go DROP.
REQ-025 DROP: accept and discard all beats; beat with eop -> IDLE; beat with sop+eop -> IDLE, no write; beat with sop only -> handled as IDLE+sop, go RECV/IDLE per REQ-020.
REQ-026 Write latency: fifo_write/fifo_data registered, high exactly one cycle after acceptance; fifo_data holds last written value otherwise.
REQ-027 pkt_done, pkt_len, pkt_count update in the same cycle fifo_write carries eop bit 1.
REQ-028 cnt_clear zeroes pkt_count and error counters; if coincident with an increment, clear wins (result 0); pkt_len and state unaffected.
REQ-029 FIFO never written while it has fewer than 1 free word, given REQ-011 and REQ-018.

Reset
REQ-030 While rsi_reset_n low: state IDLE, wcnt 0, asi_ready 0, fifo_write 0, fifo_data 0, pkt_done 0, pkt_len 0, all counters 0.
REQ-031 Reset mid-packet abandons packet without writing eop; first cycle after release asi_ready goes 1 if fifo_almost_full low.

Verification
REQ-032 4-beat packet (sop beat 0, eop beat 3), data 0x1..0x4 -> 4 writes, fifo_data[65:64]=01,00,00,10, pkt_done once, pkt_len=4, pkt_count=1.
REQ-033 Beat without sop then sop/eop single beat 0xAA -> err_orphan=1, one write {1,1,0xAA}, pkt_count=1.
REQ-034 MAX_WORDS=4, 6-beat packet -> 4 writes, 4th has eop bit 1, err_trunc=1, beats 5-6 dropped, pkt_len=4.
REQ-035 sop, 2 beats, then sop..eop 3 beats -> err_no_eop=1, 6 writes, pkt_count=1, pkt_len=3.
REQ-036 fifo_almost_full asserted mid-packet with valid held high -> asi_ready low next cycle, no beat lost or duplicated after deassertion.
REQ-037 Reset pulse during beat 2 of 4 -> all outputs 0, next clean packet counted correctly as pkt_count=1.
